// File: rtl/hazard_control.sv
// ---------------------------------------------------------------------------
// hazard_control
//   Pipeline hazard and stall controller for the RV32I five-stage core.
//   Resolves hazards that forwarding cannot cover (load-use, branch-in-ID
//   operand dependencies, taken-branch/jump redirects) and freezes the whole
//   pipeline while the data memory inserts wait states, with a timeout that
//   forces release. Keeps saturating stall and flush performance counters.
//
// Parameters
//   MEM_TIMEOUT  max consecutive WAIT cycles before forced release (>= 1)
//   CNT_W        performance counter width
//
// Ports
//   clk, rst_n                         clock, synchronous active-low reset
//   IFIDrs1/2, IFID_usesRs1/2          ID source registers and their use flags
//   IFID_isBranch                      ID holds a branch/jalr resolved in ID
//   IDEXrd, IDEX_RegWrite, IDEX_MemRead  EX-stage destination info
//   EXMEMrd, EXMEM_MemRead             MEM-stage destination info
//   branch_taken, jump                 redirect requests from ID
//   dmem_req, dmem_ready               data-memory handshake
//   PCWrite..EXMEMWrite                pipeline register enables (comb)
//   IFIDFlush, IDEXFlush, MEMWBFlush   bubble insertion (comb)
//   mem_timeout                        sticky timeout flag
//   stall_cycles, flush_count          saturating performance counters
// ---------------------------------------------------------------------------
module hazard_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IFIDrs1,
    input  logic [4:0]       IFIDrs2,
    input  logic             IFID_usesRs1,
    input  logic             IFID_usesRs2,
    input  logic             IFID_isBranch,
    input  logic [4:0]       IDEXrd,
    input  logic             IDEX_RegWrite,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       EXMEMrd,
    input  logic             EXMEM_MemRead,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEXWrite,
    output logic             EXMEMWrite,
    output logic             IFIDFlush,
    output logic             IDEXFlush,
    output logic             MEMWBFlush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [WC_W-1:0]   wait_cnt_r;
    logic              mem_timeout_r;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  flush_cnt_r;

    logic              load_use_s;
    logic              br_alu_s;
    logic              br_load_s;
    logic              data_stall_s;
    logic              redirect_s;
    logic              timeout_hit_s;
    logic              mem_wait_s;

    // A producer only matters if it writes a real register that ID actually reads.
    function automatic logic reg_match(
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       uses_rs1,
        input logic       uses_rs2
    );
        reg_match = (rd != 5'd0) &&
                    (((rd == rs1) && uses_rs1) || ((rd == rs2) && uses_rs2));
    endfunction

    assign load_use_s   = IDEX_MemRead & IDEX_RegWrite &
                          reg_match(IDEXrd, IFIDrs1, IFIDrs2, IFID_usesRs1, IFID_usesRs2);
    // Branch compares in ID, so an ALU result still in EX cannot be forwarded in time.
    assign br_alu_s     = IFID_isBranch & IDEX_RegWrite & ~IDEX_MemRead &
                          reg_match(IDEXrd, IFIDrs1, IFIDrs2, IFID_usesRs1, IFID_usesRs2);
    // Load data only exists at the end of MEM, one cycle too late for an ID compare.
    assign br_load_s    = IFID_isBranch & EXMEM_MemRead &
                          reg_match(EXMEMrd, IFIDrs1, IFIDrs2, IFID_usesRs1, IFID_usesRs2);
    assign data_stall_s = load_use_s | br_alu_s | br_load_s;
    assign redirect_s   = branch_taken | jump;

    // The cycle the counter reaches the limit releases the freeze and completes the access.
    assign timeout_hit_s = (state_r == ST_WAIT) && (wait_cnt_r == WC_W'(MEM_TIMEOUT));
    assign mem_wait_s    = dmem_req & ~dmem_ready & ~timeout_hit_s;

    // State register, wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_RUN;
            wait_cnt_r    <= {WC_W{1'b0}};
            mem_timeout_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == ST_WAIT) && (state_nxt_s == ST_WAIT)) begin
                wait_cnt_r <= wait_cnt_r + WC_W'(1);
            end else begin
                wait_cnt_r <= {WC_W{1'b0}};
            end
            if (timeout_hit_s && dmem_req && !dmem_ready) begin
                mem_timeout_r <= 1'b1;
            end else begin
                mem_timeout_r <= mem_timeout_r;
            end
        end
    end

    // Next-state logic for the memory-wait FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (dmem_req && !dmem_ready) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_WAIT: begin
                if (dmem_ready || timeout_hit_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // Enable/flush outputs in priority order: reset, memory freeze, data stall, redirect.
    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IDEXWrite  = 1'b1;
        EXMEMWrite = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXFlush  = 1'b0;
        MEMWBFlush = 1'b0;
        if (!rst_n) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXWrite  = 1'b0;
            EXMEMWrite = 1'b0;
            IFIDFlush  = 1'b1;
            IDEXFlush  = 1'b1;
            MEMWBFlush = 1'b1;
        end else if (mem_wait_s) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXWrite  = 1'b0;
            EXMEMWrite = 1'b0;
            MEMWBFlush = 1'b1;
        end else if (data_stall_s) begin
            // Redirect is dropped: branch operands are not valid yet.
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXFlush  = 1'b1;
        end else if (redirect_s) begin
            IFIDFlush  = 1'b1;
        end else begin
            IFIDFlush  = 1'b0;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if ((mem_wait_s || data_stall_s) && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (redirect_s && !mem_wait_s && !data_stall_s &&
                (flush_cnt_r != {CNT_W{1'b1}})) begin
                flush_cnt_r <= flush_cnt_r + CNT_W'(1);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign mem_timeout  = mem_timeout_r;
    assign stall_cycles = stall_cnt_r;
    assign flush_count  = flush_cnt_r;

endmodule

// File: tb/tb_hazard_control.sv
// ---------------------------------------------------------------------------
// tb_hazard_control
//   Self-checking bench for hazard_control. Two instances share all inputs:
//   a 32-bit counter version and a 4-bit counter version for saturation.
//   Both use MEM_TIMEOUT=4. Each cycle's expected controls and sticky flag
//   are queued when the inputs are driven and compared mid-cycle; counters
//   are compared against a running model derived from the expected controls.
// ---------------------------------------------------------------------------
module tb_hazard_control;

    localparam logic [6:0] C_RUN   = 7'b1111_000;
    localparam logic [6:0] C_STALL = 7'b0011_010;
    localparam logic [6:0] C_MEMW  = 7'b0000_001;
    localparam logic [6:0] C_REDIR = 7'b1111_100;
    localparam logic [6:0] C_RST   = 7'b0000_111;

    typedef struct {
        logic       rst_n;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       br;
        logic [4:0] idrd;
        logic       rw;
        logic       mr;
        logic [4:0] exrd;
        logic       exmr;
        logic       bt;
        logic       jp;
        logic       req;
        logic       rdy;
        logic [6:0] ctrl;
        logic       mt;
    } vec_t;

    typedef struct {
        logic [6:0] ctrl;
        logic       mt;
        logic       rst_n;
    } exp_t;

    logic clk;
    logic rst_n;
    logic [4:0] rs1, rs2, idrd, exrd;
    logic u1, u2, br, rw, mr, exmr, bt, jp, req, rdy;

    logic pcw, ifidw, idexw, exmemw, ifidf, idexf, memwbf, mt;
    logic [31:0] stall_c, flush_c;
    logic pcw_s, ifidw_s, idexw_s, exmemw_s, ifidf_s, idexf_s, memwbf_s, mt_s;
    logic [3:0] stall_c_s, flush_c_s;

    int checks = 0;
    int errors = 0;
    int step   = 0;
    int model_stall = 0;
    int model_flush = 0;
    exp_t q[$];
    vec_t tbl[18];

    hazard_control #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .IFIDrs1(rs1), .IFIDrs2(rs2), .IFID_usesRs1(u1), .IFID_usesRs2(u2),
        .IFID_isBranch(br), .IDEXrd(idrd), .IDEX_RegWrite(rw), .IDEX_MemRead(mr),
        .EXMEMrd(exrd), .EXMEM_MemRead(exmr), .branch_taken(bt), .jump(jp),
        .dmem_req(req), .dmem_ready(rdy),
        .PCWrite(pcw), .IFIDWrite(ifidw), .IDEXWrite(idexw), .EXMEMWrite(exmemw),
        .IFIDFlush(ifidf), .IDEXFlush(idexf), .MEMWBFlush(memwbf),
        .mem_timeout(mt), .stall_cycles(stall_c), .flush_count(flush_c)
    );

    hazard_control #(.MEM_TIMEOUT(4), .CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .IFIDrs1(rs1), .IFIDrs2(rs2), .IFID_usesRs1(u1), .IFID_usesRs2(u2),
        .IFID_isBranch(br), .IDEXrd(idrd), .IDEX_RegWrite(rw), .IDEX_MemRead(mr),
        .EXMEMrd(exrd), .EXMEM_MemRead(exmr), .branch_taken(bt), .jump(jp),
        .dmem_req(req), .dmem_ready(rdy),
        .PCWrite(pcw_s), .IFIDWrite(ifidw_s), .IDEXWrite(idexw_s), .EXMEMWrite(exmemw_s),
        .IFIDFlush(ifidf_s), .IDEXFlush(idexf_s), .MEMWBFlush(memwbf_s),
        .mem_timeout(mt_s), .stall_cycles(stall_c_s), .flush_count(flush_c_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic rst_v, input logic [4:0] rs1_v, input logic [4:0] rs2_v,
        input logic u1_v, input logic u2_v, input logic br_v,
        input logic [4:0] idrd_v, input logic rw_v, input logic mr_v,
        input logic [4:0] exrd_v, input logic exmr_v,
        input logic bt_v, input logic jp_v, input logic req_v, input logic rdy_v,
        input logic [6:0] ctrl_v, input logic mt_v
    );
        vec_t v;
        v.rst_n = rst_v; v.rs1 = rs1_v; v.rs2 = rs2_v; v.u1 = u1_v; v.u2 = u2_v;
        v.br = br_v; v.idrd = idrd_v; v.rw = rw_v; v.mr = mr_v; v.exrd = exrd_v;
        v.exmr = exmr_v; v.bt = bt_v; v.jp = jp_v; v.req = req_v; v.rdy = rdy_v;
        v.ctrl = ctrl_v; v.mt = mt_v;
        return v;
    endfunction

    function automatic vec_t idle(input logic mt_v);
        return mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0,
                  1'b0, 1'b0, 1'b0, 1'b0, C_RUN, mt_v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp_v);
        end
    endtask

    // Drive one cycle, queue its expectation, compare at the falling edge.
    task automatic run(input vec_t v);
        exp_t e;
        int sat;
        rst_n = v.rst_n; rs1 = v.rs1; rs2 = v.rs2; u1 = v.u1; u2 = v.u2; br = v.br;
        idrd = v.idrd; rw = v.rw; mr = v.mr; exrd = v.exrd; exmr = v.exmr;
        bt = v.bt; jp = v.jp; req = v.req; rdy = v.rdy;
        e.ctrl = v.ctrl; e.mt = v.mt; e.rst_n = v.rst_n;
        q.push_back(e);
        @(negedge clk);
        e = q.pop_front();
        chk("ctrl", 32'({pcw, ifidw, idexw, exmemw, ifidf, idexf, memwbf}), 32'(e.ctrl));
        chk("mem_timeout", 32'(mt), 32'(e.mt));
        chk("stall_cycles", stall_c, 32'(model_stall));
        chk("flush_count", flush_c, 32'(model_flush));
        sat = (model_stall > 15) ? 15 : model_stall;
        chk("stall_cycles_sat", 32'(stall_c_s), 32'(sat));
        if (!e.rst_n) begin
            model_stall = 0;
            model_flush = 0;
        end else if (!e.ctrl[6]) begin
            model_stall++;
        end else if (e.ctrl[2]) begin
            model_flush++;
        end
        step++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        // Pure single-cycle hazard vectors, all evaluated in RUN state.
        tbl[0]  = idle(1'b0);
        tbl[1]  = mk(1, 5, 1, 1, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, C_STALL, 0); // load-use rs1
        tbl[2]  = mk(1, 2, 7, 1, 1, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0, C_STALL, 0); // load-use rs2
        tbl[3]  = mk(1, 0, 3, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, C_RUN,   0); // rd=0
        tbl[4]  = mk(1, 1, 9, 1, 0, 0, 9, 1, 1, 0, 0, 0, 0, 0, 0, C_RUN,   0); // rs2 unused
        tbl[5]  = mk(1, 3, 0, 1, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, C_STALL, 0); // br_alu
        tbl[6]  = mk(1, 3, 0, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, C_RUN,   0); // alu dep, forwarded
        tbl[7]  = mk(1, 0, 4, 0, 1, 1, 0, 0, 0, 4, 1, 0, 0, 0, 0, C_STALL, 0); // br_load
        tbl[8]  = mk(1, 0, 4, 0, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, C_RUN,   0); // non-branch, load in MEM
        tbl[9]  = mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, C_REDIR, 0); // taken branch
        tbl[10] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_REDIR, 0); // jal
        tbl[11] = mk(1, 5, 0, 1, 0, 1, 5, 1, 1, 0, 0, 1, 0, 0, 0, C_STALL, 0); // stall beats redirect
        tbl[12] = mk(1, 5, 6, 1, 1, 1, 5, 1, 1, 6, 1, 0, 0, 0, 0, C_STALL, 0); // load_use + br_load
        tbl[13] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_RUN,   0); // ready same cycle
        tbl[14] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, C_REDIR, 0); // ready + jump
        tbl[15] = mk(1, 5, 0, 1, 0, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0, C_RUN,   0); // load w/o RegWrite
        tbl[16] = mk(1, 0, 8, 0, 1, 1, 8, 1, 0, 9, 1, 0, 0, 0, 0, C_STALL, 0); // br_alu rs2
        tbl[17] = mk(1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, C_RUN,   0); // x0 load

        rst_n = 1'b0; rs1 = 5'd0; rs2 = 5'd0; idrd = 5'd0; exrd = 5'd0;
        u1 = 1'b0; u2 = 1'b0; br = 1'b0; rw = 1'b0; mr = 1'b0; exmr = 1'b0;
        bt = 1'b0; jp = 1'b0; req = 1'b0; rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        v = idle(1'b0); v.rst_n = 1'b0; v.ctrl = C_RST;
        run(v);
        for (int i = 0; i < 18; i++) run(tbl[i]);

        // lw x5 ; add x6,x5,x1 : one bubble then flow.
        run(mk(1, 5, 1, 1, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, C_STALL, 0));
        run(mk(1, 5, 1, 1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, C_RUN,   0));

        // lw x5 ; beq x5,x0 : load_use, br_load, then taken redirect.
        run(mk(1, 5, 0, 1, 1, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0, C_STALL, 0));
        run(mk(1, 5, 0, 1, 1, 1, 0, 0, 0, 5, 1, 0, 0, 0, 0, C_STALL, 0));
        run(mk(1, 5, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, C_REDIR, 0));

        // Three wait cycles (one with hazard + redirect inputs), then ready.
        v = idle(1'b0); v.req = 1'b1; v.ctrl = C_MEMW;
        run(v);
        run(v);
        run(mk(1, 5, 0, 1, 0, 1, 5, 1, 1, 0, 0, 1, 0, 1, 0, C_MEMW, 0));
        v.rdy = 1'b1; v.ctrl = C_RUN;
        run(v);
        run(idle(1'b0));

        // 20 load-use stalls: the 4-bit counter pins at 15.
        for (int i = 0; i < 20; i++)
            run(mk(1, 5, 1, 1, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, C_STALL, 0));

        // Timeout: reset, 5 frozen cycles, forced release, sticky flag until reset.
        v = idle(1'b0); v.rst_n = 1'b0; v.ctrl = C_RST;
        run(v);
        v = idle(1'b0); v.req = 1'b1; v.ctrl = C_MEMW;
        for (int i = 0; i < 5; i++) run(v);
        v.ctrl = C_RUN;
        run(v);
        run(idle(1'b1));
        run(idle(1'b1));
        v = idle(1'b1); v.rst_n = 1'b0; v.ctrl = C_RST;
        run(v);
        run(idle(1'b0));

        // Reset in WAIT: back to RUN, so a fresh full-length timeout follows.
        v = idle(1'b0); v.req = 1'b1; v.ctrl = C_MEMW;
        run(v);
        run(v);
        v.rst_n = 1'b0; v.ctrl = C_RST;
        run(v);
        v.rst_n = 1'b1; v.ctrl = C_MEMW;
        for (int i = 0; i < 5; i++) run(v);
        v.ctrl = C_RUN;
        run(v);
        run(idle(1'b1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_control.md
# hazard_control

Pipeline hazard and stall controller for the RV32I five-stage core; sits beside the forwarding unit and drives the enable/flush inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves hazards that forwarding cannot cover: load-use, branch-in-ID operand dependencies and taken-branch/jump redirects. It also freezes the pipeline during data-memory wait states, with a timeout. It keeps saturating stall and flush performance counters.

## Interface
- MEM_TIMEOUT, 16: max consecutive data-memory wait cycles before forced release (≥1)
- CNT_W, 32: performance counter width
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- IFIDrs1, IFIDrs2  in  5 each  source registers of the instruction in ID
- IFID_usesRs1, IFID_usesRs2  in  1 each  the ID instruction actually reads rs1 / rs2
- IFID_isBranch  in  1  ID instruction is a conditional branch or jalr (compared/resolved in ID)
- IDEXrd  in  5  destination of the EX instruction
- IDEX_RegWrite, IDEX_MemRead  in  1 each  EX instruction writes a register / is a load
- EXMEMrd  in  5  destination of the MEM instruction
- EXMEM_MemRead  in  1  MEM instruction is a load
- branch_taken  in  1  ID resolved a taken branch or jalr
- jump  in  1  ID holds a jal
- dmem_req  in  1  MEM stage has an active load/store
- dmem_ready  in  1  data memory completes the access this cycle
- PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite  out  1 each  register enables
- IFIDFlush, IDEXFlush, MEMWBFlush  out  1 each  insert a bubble on the next edge
- mem_timeout  out  1  sticky flag set when a memory wait hit MEM_TIMEOUT
- stall_cycles, flush_count  out  CNT_W each  saturating performance counters

## Operation
- A register match requires rd ≠ 0, rd equal to the relevant rs, and that rs's uses flag set.
- load_use = IDEX_MemRead & IDEX_RegWrite & match(IDEXrd).
- br_alu = IFID_isBranch & IDEX_RegWrite & !IDEX_MemRead & match(IDEXrd). This stalls 1 cycle.
- br_load = IFID_isBranch & EXMEM_MemRead & match(EXMEMrd). A branch behind a load therefore stalls 2 cycles in total: load_use, then br_load.
- data_stall = load_use | br_alu | br_load.
- FSM states:
  - RUN → WAIT when dmem_req & !dmem_ready.
  - WAIT → RUN when dmem_ready, or when wait_cnt reaches MEM_TIMEOUT.
  - wait_cnt is cleared on entry to WAIT and increments each WAIT cycle.
- mem_wait = dmem_req & !dmem_ready & !(state==WAIT & wait_cnt==MEM_TIMEOUT). On the release cycle, set mem_timeout and treat the access as complete.
- Output priority (combinational, highest first):
  - rst_n=0: every enable = 0; IFIDFlush = IDEXFlush = MEMWBFlush = 1.
  - mem_wait: PCWrite = IFIDWrite = IDEXWrite = EXMEMWrite = 0; MEMWBFlush = 1; other flushes 0. Redirects are ignored; ID is frozen and re-evaluates next cycle.
  - data_stall: PCWrite = IFIDWrite = 0; IDEXFlush = 1; IDEXWrite = EXMEMWrite = 1; IFIDFlush = 0. A redirect is suppressed because branch operands are not yet valid.
  - branch_taken | jump: all enables 1; IFIDFlush = 1.
  - Otherwise: all enables 1, all flushes 0.
- stall_cycles increments on every cycle where mem_wait | data_stall.
- flush_count increments on every redirect cycle (priority case 4).
- Both counters saturate at all-ones.

## Timing
- All enable/flush outputs are combinational from inputs and state, valid in the same cycle. There is no added latency.
- Synchronous reset, sampled on clk when rst_n=0:
  - state = RUN, wait_cnt = 0, mem_timeout = 0, counters = 0.
  - Outputs follow the rst_n=0 row above.
- Reset mid-WAIT returns to RUN on the next edge and clears mem_timeout.
- dmem_ready high in the same cycle as dmem_req causes no stall and no WAIT entry.
- The longest wait is MEM_TIMEOUT+1 stalled cycles: 1 in RUN plus MEM_TIMEOUT in WAIT.
- The release cycle is not counted as a stall.
- mem_timeout stays set until reset.
- Simultaneous load_use and br_load: a single stall cycle that cycle; IDEXFlush = 1.

## Test plan
- lw x5 in EX, add x6,x5,x1 in ID (usesRs1=1) -> one cycle with PCWrite=0, IFIDWrite=0, IDEXFlush=1; next cycle all enables 1; stall_cycles=1.
- lw x5 in EX, beq x5,x0 in ID -> two stall cycles (load_use, then br_load with EXMEMrd=5); the third cycle with branch_taken=1 gives IFIDFlush=1 and flush_count=1.
- IDEXrd=0 with IDEX_MemRead=1 and IFIDrs1=0 -> no stall. Also usesRs2=0 with an IFIDrs2 match -> no stall.
- dmem_req=1, dmem_ready low for 3 cycles then high -> 3 cycles with MEMWBFlush=1 and EXMEMWrite=0, no stall on the ready cycle, mem_timeout=0, stall_cycles=3.
- MEM_TIMEOUT=4, dmem_ready stuck low -> 5 stalled cycles, release on the 6th with enables 1, mem_timeout=1; it stays 1 until rst_n=0, and that reset restores all counters to 0.
- rst_n low during WAIT -> flushes all 1 and enables 0 that cycle; RUN state after the edge. CNT_W=4 with 20 stalls -> stall_cycles=15.
